// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32I core: stalls, flushes, EX forwarding, fetch waits.
// Define HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters (width CNT_W).
module hazard_ctrl #(
   parameter int LOAD_USE_CYCLES = 1
`ifdef HAZARD_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic       LoadE,
   input  logic       PCSrcE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       imem_ready,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE
`ifdef HAZARD_PERF_EN
   , output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   typedef enum logic {RUN, LDSTALL} state_t;

   localparam logic [3:0] LU_INIT = 4'(LOAD_USE_CYCLES - 1);

   state_t     state, state_next;
   logic [3:0] cnt, cnt_next;
   logic       lu;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   assign lu = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // MEM result is younger than WB, so it wins when both write the same register
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
         sel = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst) begin
         ForwardAE = fwd_sel(Rs1E);
         ForwardBE = fwd_sel(Rs2E);
      end
   end

   // Branch redirect beats load stalls, which beat instruction-memory waits
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      StallF     = 1'b0;
      StallD     = 1'b0;
      FlushD     = 1'b0;
      FlushE     = 1'b0;
      if (rst) begin
         state_next = RUN;
         cnt_next   = '0;
      end else if (PCSrcE) begin
         FlushD     = 1'b1;
         FlushE     = 1'b1;
         state_next = RUN;
         cnt_next   = '0;
      end else if (state == LDSTALL) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
         if (cnt <= 4'd1) begin
            state_next = RUN;
            cnt_next   = '0;
         end else begin
            cnt_next = cnt - 4'd1;
         end
      end else if (lu) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
         if (LOAD_USE_CYCLES > 1) begin
            state_next = LDSTALL;
            cnt_next   = LU_INIT;
         end
      end else if (!imem_ready) begin
         StallF = 1'b1;
         FlushD = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (StallF)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (PCSrcE)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with LOAD_USE_CYCLES of 1, 3 and 5 side by side.
// Counter checks run only when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic LoadE, PCSrcE, RegWriteM, RegWriteW, imem_ready;

   wire [7:0] o1, o3, o5;
`ifdef HAZARD_PERF_EN
   wire [1:0]  sc1, fc1;
   wire [31:0] sc3, fc3, sc5, fc5;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_USE_CYCLES(1)
`ifdef HAZARD_PERF_EN
      , .CNT_W(2)
`endif
   ) dut1 (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .LoadE(LoadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .imem_ready(imem_ready), .StallF(o1[7]), .StallD(o1[6]),
      .FlushD(o1[5]), .FlushE(o1[4]), .ForwardAE(o1[3:2]), .ForwardBE(o1[1:0])
`ifdef HAZARD_PERF_EN
      , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
   );

   hazard_ctrl #(.LOAD_USE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .LoadE(LoadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .imem_ready(imem_ready), .StallF(o3[7]), .StallD(o3[6]),
      .FlushD(o3[5]), .FlushE(o3[4]), .ForwardAE(o3[3:2]), .ForwardBE(o3[1:0])
`ifdef HAZARD_PERF_EN
      , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
   );

   hazard_ctrl #(.LOAD_USE_CYCLES(5)) dut5 (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .LoadE(LoadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .imem_ready(imem_ready), .StallF(o5[7]), .StallD(o5[6]),
      .FlushD(o5[5]), .FlushE(o5[4]), .ForwardAE(o5[3:2]), .ForwardBE(o5[1:0])
`ifdef HAZARD_PERF_EN
      , .stall_cnt(sc5), .flush_cnt(fc5)
`endif
   );

   // Output vector layout: {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}
   localparam logic [7:0] IDLE = 8'b0000_0000;
   localparam logic [7:0] LDST = 8'b1101_0000;
   localparam logic [7:0] BRF  = 8'b0011_0000;
   localparam logic [7:0] IMW  = 8'b1010_0000;

   typedef struct {
      string       tag;
      int          id;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] observe(input int id);
      case (id)
         1:  return {24'd0, o1};
         3:  return {24'd0, o3};
         5:  return {24'd0, o5};
`ifdef HAZARD_PERF_EN
         10: return sc3;
         11: return fc3;
         12: return {30'd0, sc1};
         13: return {30'd0, fc1};
`endif
         default: return 'x;
      endcase
   endfunction

   task automatic applyStimulus(input string tag, input int id, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.id  = id;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic expectAll(input string tag, input logic [7:0] e1, input logic [7:0] e3,
                            input logic [7:0] e5);
      applyStimulus(tag, 1, {24'd0, e1});
      applyStimulus(tag, 3, {24'd0, e3});
      applyStimulus(tag, 5, {24'd0, e5});
   endtask

   task automatic checkOutput();
      sb_item_t    it;
      logic [31:0] got;
      #1;
      while (sb_q.size() > 0) begin
         it  = sb_q.pop_front();
         got = observe(it.id);
         total++;
         assert (got === it.exp) else begin
            bad++;
            $error("[TB] FAIL %s dut=%0d got=%h exp=%h", it.tag, it.id, got, it.exp);
         end
      end
   endtask

   task automatic setIdle();
      Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
      RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
      LoadE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      imem_ready = 1'b1;
   endtask

   task automatic setLoadUse();
      LoadE = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      setIdle();
      // hazardous inputs held during reset must all be masked
      RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; setLoadUse(); imem_ready = 1'b0; PCSrcE = 1'b1;
      nextCycle(); expectAll("reset_hold", IDLE, IDLE, IDLE); checkOutput();
      nextCycle(); rst = 1'b0; setIdle(); expectAll("reset_release", IDLE, IDLE, IDLE); checkOutput();

      nextCycle(); RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs2E = 5'd7;
      expectAll("fwd_mem_prio", 8'b0000_1000, 8'b0000_1000, 8'b0000_1000); checkOutput();
      nextCycle(); RdM = 5'd0;
      expectAll("fwd_rdm_zero", 8'b0000_0100, 8'b0000_0100, 8'b0000_0100); checkOutput();
      nextCycle(); RegWriteM = 1'b1; RdM = 5'd7; Rs2E = 5'd7; Rs1E = 5'd5; RdW = 5'd5;
      expectAll("fwd_a_wb_b_mem", 8'b0000_0110, 8'b0000_0110, 8'b0000_0110); checkOutput();
      nextCycle(); RegWriteM = 1'b0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd7;
      expectAll("fwd_none", IDLE, IDLE, IDLE); checkOutput();

      nextCycle(); setIdle(); setLoadUse(); expectAll("lu_c1", LDST, LDST, LDST); checkOutput();
      nextCycle(); setIdle(); expectAll("lu_c2", IDLE, LDST, LDST); checkOutput();
      nextCycle(); expectAll("lu_c3", IDLE, LDST, LDST); checkOutput();
      nextCycle(); expectAll("lu_c4", IDLE, IDLE, LDST); checkOutput();
      nextCycle(); expectAll("lu_c5", IDLE, IDLE, LDST); checkOutput();
      nextCycle(); expectAll("lu_c6", IDLE, IDLE, IDLE); checkOutput();
      nextCycle(); setLoadUse(); RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
      expectAll("lu_rde_zero", IDLE, IDLE, IDLE); checkOutput();
      nextCycle(); setIdle(); LoadE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
      expectAll("lu_rs1", LDST, LDST, LDST); checkOutput();
      nextCycle(); setIdle(); PCSrcE = 1'b1;
      expectAll("lu_rs1_brk", BRF, BRF, BRF); checkOutput();

      nextCycle(); setIdle(); PCSrcE = 1'b1; expectAll("branch", BRF, BRF, BRF); checkOutput();
      nextCycle(); setIdle(); setLoadUse(); PCSrcE = 1'b1;
      expectAll("branch_over_lu", BRF, BRF, BRF); checkOutput();
      nextCycle(); setIdle(); expectAll("branch_over_lu_after", IDLE, IDLE, IDLE); checkOutput();
      nextCycle(); setLoadUse(); expectAll("ldbr_c1", LDST, LDST, LDST); checkOutput();
      nextCycle(); setIdle(); PCSrcE = 1'b1; expectAll("ldbr_c2", BRF, BRF, BRF); checkOutput();
      nextCycle(); setIdle(); expectAll("ldbr_c3", IDLE, IDLE, IDLE); checkOutput();

      for (int i = 0; i < 4; i++) begin
         nextCycle(); setIdle(); imem_ready = 1'b0;
         expectAll("imem_wait", IMW, IMW, IMW); checkOutput();
      end
      nextCycle(); setIdle(); expectAll("imem_done", IDLE, IDLE, IDLE); checkOutput();

      nextCycle(); setLoadUse(); imem_ready = 1'b0; expectAll("imlu_c1", LDST, LDST, LDST); checkOutput();
      nextCycle(); setIdle(); imem_ready = 1'b0; expectAll("imlu_c2", IMW, LDST, LDST); checkOutput();
      nextCycle(); expectAll("imlu_c3", IMW, LDST, LDST); checkOutput();
      nextCycle(); expectAll("imlu_c4", IMW, IMW, LDST); checkOutput();
      nextCycle(); imem_ready = 1'b1; expectAll("imlu_c5", IDLE, IDLE, LDST); checkOutput();
      nextCycle(); expectAll("imlu_c6", IDLE, IDLE, IDLE); checkOutput();

      nextCycle(); setLoadUse(); expectAll("rst_c1", LDST, LDST, LDST); checkOutput();
      nextCycle(); setIdle(); expectAll("rst_c2", IDLE, LDST, LDST); checkOutput();
      #2 rst = 1'b1; RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
      expectAll("rst_async", IDLE, IDLE, IDLE); checkOutput();
      nextCycle(); rst = 1'b0; setIdle(); expectAll("rst_after1", IDLE, IDLE, IDLE); checkOutput();
      nextCycle(); expectAll("rst_after2", IDLE, IDLE, IDLE); checkOutput();

`ifdef HAZARD_PERF_EN
      nextCycle(); rst = 1'b1;
      nextCycle(); rst = 1'b0; setIdle();
      nextCycle(); setLoadUse();
      nextCycle(); setIdle();
      nextCycle();
      nextCycle(); PCSrcE = 1'b1;
      nextCycle();
      nextCycle(); setIdle();
      applyStimulus("perf_stall3", 10, 32'd3);
      applyStimulus("perf_flush2", 11, 32'd2);
      checkOutput();
      nextCycle(); rst = 1'b1;
      nextCycle(); rst = 1'b0; setIdle();
      for (int i = 0; i < 5; i++) begin
         nextCycle(); imem_ready = 1'b0;
      end
      nextCycle(); setIdle();
      applyStimulus("perf_wrap", 12, 32'd1);
      applyStimulus("perf_wrap_flush", 13, 32'd0);
      applyStimulus("perf_stall5", 10, 32'd5);
      checkOutput();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
